// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer-phase state encoding and default bus widths,
// used by the requester and by the register slaves.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_t;

    localparam int APB_DW_DEF = 32;
    localparam int APB_AW_DEF = 5;

endpackage : apb_pkg

// File: rtl/apb_master.sv
// APB4 requester: single-beat valid/ready commands become SETUP/ACCESS transfers,
// one response pulse per command. Optional wait-state abort under APB_MASTER_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int  DW        = APB_DW_DEF,
    parameter int  AW        = APB_AW_DEF,
    parameter int  TO_CYCLES = 16,
    localparam int SW        = DW / 8
) (
    input  logic          pclk,
    input  logic          preset,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [AW-1:0] i_cmd_addr,
    input  logic          i_cmd_write,
    input  logic [DW-1:0] i_cmd_wdata,
    input  logic [SW-1:0] i_cmd_strb,
    output logic          o_rsp_valid,
    output logic [DW-1:0] o_rsp_rdata,
    output logic          o_rsp_slverr,
    output logic          o_rsp_timeout,
    output logic [AW-1:0] o_paddr,
    output logic          o_pwrite,
    output logic          o_psel,
    output logic          o_penable,
    output logic [DW-1:0] o_pwdata,
    output logic [SW-1:0] o_pstrb,
    input  logic [DW-1:0] i_prdata,
    input  logic          i_pslverr,
    input  logic          i_pready
);

    apb_state_t    state_r;
    apb_state_t    next_state_s;
    logic          handshake_s;
    logic          done_s;
    logic          timeout_s;

    logic          psel_r;
    logic          penable_r;
    logic [AW-1:0] paddr_r;
    logic          pwrite_r;
    logic [DW-1:0] pwdata_r;
    logic [SW-1:0] pstrb_r;

    logic          rsp_valid_r;
    logic [DW-1:0] rsp_rdata_r;
    logic          rsp_slverr_r;
    logic          rsp_timeout_r;

    assign handshake_s = i_cmd_valid && (state_r == IDLE);
    assign done_s      = (state_r == ACCESS) && i_pready;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES + 1);

    logic [CW-1:0] to_cnt_r;

    // Wait-state counter: zeroed in SETUP so it starts clean on entering ACCESS
    always_ff @(posedge pclk) begin
        if (preset) begin
            to_cnt_r <= {CW{1'b0}};
        end else if (state_r == SETUP) begin
            to_cnt_r <= {CW{1'b0}};
        end else if ((state_r == ACCESS) && !i_pready && (to_cnt_r != CW'(TO_CYCLES))) begin
            to_cnt_r <= to_cnt_r + CW'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // The wait cycle that brings the count to TO_CYCLES is the last one; pready in it still wins
    assign timeout_s = (state_r == ACCESS) && !i_pready && (to_cnt_r == CW'(TO_CYCLES - 1));
`else
    // TO_CYCLES is non-negative, so this is a constant 0 that keeps the parameter referenced
    assign timeout_s = (TO_CYCLES < 0);
`endif

    // Transfer-phase state register
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_cmd_valid) begin
                    next_state_s = SETUP;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SETUP: begin
                next_state_s = ACCESS;
            end
            ACCESS: begin
                if (done_s || timeout_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = ACCESS;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // APB request registers; fields are loaded only on handshake so they stay stable and hold in IDLE
    always_ff @(posedge pclk) begin
        if (preset) begin
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            paddr_r   <= {AW{1'b0}};
            pwrite_r  <= 1'b0;
            pwdata_r  <= {DW{1'b0}};
            pstrb_r   <= {SW{1'b0}};
        end else begin
            psel_r    <= (next_state_s != IDLE);
            penable_r <= (next_state_s == ACCESS);
            if (handshake_s) begin
                paddr_r  <= i_cmd_addr;
                pwrite_r <= i_cmd_write;
                pwdata_r <= i_cmd_write ? i_cmd_wdata : {DW{1'b0}};
                pstrb_r  <= i_cmd_write ? i_cmd_strb  : {SW{1'b0}};
            end else begin
                paddr_r  <= paddr_r;
                pwrite_r <= pwrite_r;
                pwdata_r <= pwdata_r;
                pstrb_r  <= pstrb_r;
            end
        end
    end

    // Response registers: fields are non-zero only during the one-cycle valid pulse
    always_ff @(posedge pclk) begin
        if (preset) begin
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {DW{1'b0}};
            rsp_slverr_r  <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else if (done_s) begin
            rsp_valid_r   <= 1'b1;
            rsp_rdata_r   <= pwrite_r ? {DW{1'b0}} : i_prdata;
            rsp_slverr_r  <= i_pslverr;
            rsp_timeout_r <= 1'b0;
        end else if (timeout_s) begin
            rsp_valid_r   <= 1'b1;
            rsp_rdata_r   <= {DW{1'b0}};
            rsp_slverr_r  <= 1'b1;
            rsp_timeout_r <= 1'b1;
        end else begin
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {DW{1'b0}};
            rsp_slverr_r  <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end
    end

    assign o_cmd_ready   = (state_r == IDLE);
    assign o_psel        = psel_r;
    assign o_penable     = penable_r;
    assign o_paddr       = paddr_r;
    assign o_pwrite      = pwrite_r;
    assign o_pwdata      = pwdata_r;
    assign o_pstrb       = pstrb_r;
    assign o_rsp_valid   = rsp_valid_r;
    assign o_rsp_rdata   = rsp_rdata_r;
    assign o_rsp_slverr  = rsp_slverr_r;
    assign o_rsp_timeout = rsp_timeout_r;

endmodule : apb_master

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: per-cycle vector table plus hand-written
// back-to-back and stalled-slave sequences.
module tb_apb_master;

    logic        pclk;
    logic        preset;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [4:0]  i_cmd_addr;
    logic        i_cmd_write;
    logic [31:0] i_cmd_wdata;
    logic [3:0]  i_cmd_strb;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_slverr;
    logic        o_rsp_timeout;
    logic [4:0]  o_paddr;
    logic        o_pwrite;
    logic        o_psel;
    logic        o_penable;
    logic [31:0] o_pwdata;
    logic [3:0]  o_pstrb;
    logic [31:0] i_prdata;
    logic        i_pslverr;
    logic        i_pready;

    int checks = 0;
    int errors = 0;

    apb_master #(.DW(32), .AW(5), .TO_CYCLES(4)) dut (
        .pclk(pclk), .preset(preset),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_addr(i_cmd_addr), .i_cmd_write(i_cmd_write),
        .i_cmd_wdata(i_cmd_wdata), .i_cmd_strb(i_cmd_strb),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_slverr(o_rsp_slverr), .o_rsp_timeout(o_rsp_timeout),
        .o_paddr(o_paddr), .o_pwrite(o_pwrite), .o_psel(o_psel),
        .o_penable(o_penable), .o_pwdata(o_pwdata), .o_pstrb(o_pstrb),
        .i_prdata(i_prdata), .i_pslverr(i_pslverr), .i_pready(i_pready)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic        rst;
        logic        v;
        logic [4:0]  a;
        logic        w;
        logic [31:0] wd;
        logic [3:0]  st;
        logic        rdy;
        logic        err;
        logic [31:0] rd;
        logic        chk;
        logic [79:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Expected {ready,psel,penable,paddr,pwrite,pwdata,pstrb,rsp_valid,rdata,slverr,timeout}
    function automatic logic [79:0] ex(input logic rdy_o, input logic sel, input logic en,
                                       input logic [4:0] pa, input logic pw, input logic [31:0] pwd,
                                       input logic [3:0] ps, input logic rv, input logic [31:0] rdt,
                                       input logic se);
        return {rdy_o, sel, en, pa, pw, pwd, ps, rv, rdt, se, 1'b0};
    endfunction

    function automatic vec_t mkv(input logic rst, input logic v, input logic [4:0] a, input logic w,
                                 input logic [31:0] wd, input logic [3:0] st, input logic rdy,
                                 input logic err, input logic [31:0] rd, input logic chk,
                                 input logic [79:0] e);
        vec_t r;
        r.rst = rst; r.v = v; r.a = a; r.w = w; r.wd = wd; r.st = st;
        r.rdy = rdy; r.err = err; r.rd = rd; r.chk = chk; r.exp = e;
        return r;
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] observe();
        return {o_cmd_ready, o_psel, o_penable, o_paddr, o_pwrite, o_pwdata, o_pstrb,
                o_rsp_valid, o_rsp_rdata, o_rsp_slverr, o_rsp_timeout};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d1, db, d3, cf, d5;
        logic [79:0] idl0;
        logic [4:0]  addrs [3];
        int          acc_cyc [3];
        int          nacc, nrsp, rsp_cyc, nacc_cyc;
        logic        hs;
        logic [31:0] rsp_rd;
        logic        rsp_se, rsp_to, psel_at_rsp;

        d1 = 32'hA5A5_5A5A; db = 32'hDEAD_BEEF; d3 = 32'h0000_1234;
        cf = 32'h00C0_FFEE; d5 = 32'h8765_4321;
        idl0 = ex(1'b1, 1'b0, 1'b0, 5'h00, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);

        preset = 1'b1; i_cmd_valid = 1'b0; i_cmd_addr = 5'h00; i_cmd_write = 1'b0;
        i_cmd_wdata = 32'h0; i_cmd_strb = 4'h0; i_prdata = 32'h0; i_pslverr = 1'b0; i_pready = 1'b0;

        // reset
        tbl.push_back(mkv(1'b1, 1'b0, 5'h00, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, idl0));
        tbl.push_back(mkv(1'b1, 1'b0, 5'h00, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, idl0));
        tbl.push_back(mkv(1'b0, 1'b0, 5'h00, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, idl0));
        // zero-wait write 0x08
        tbl.push_back(mkv(1'b0, 1'b1, 5'h08, 1'b1, d1, 4'hF, 1'b0, 1'b0, 32'h0, 1'b1, idl0));
        tbl.push_back(mkv(1'b0, 1'b0, 5'h00, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1, ex(1'b0, 1'b1, 1'b0, 5'h08, 1'b1, d1, 4'hF, 1'b0, 32'h0, 1'b0)));
        tbl.push_back(mkv(1'b0, 1'b0, 5'h00, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1, ex(1'b0, 1'b1, 1'b1, 5'h08, 1'b1, d1, 4'hF, 1'b0, 32'h0, 1'b0)));
        tbl.push_back(mkv(1'b0, 1'b0, 5'h00, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, ex(1'b1, 1'b0, 1'b0, 5'h08, 1'b1, d1, 4'hF, 1'b1, 32'h0, 1'b0)));
        tbl.push_back(mkv(1'b0, 1'b0, 5'h00, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, ex(1'b1, 1'b0, 1'b0, 5'h08, 1'b1, d1, 4'hF, 1'b0, 32'h0, 1'b0)));
        // read 0x0C with two wait states; wdata/strb offered must not reach the bus
        tbl.push_back(mkv(1'b0, 1'b1, 5'h0C, 1'b0, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0, 32'h0, 1'b1, ex(1'b1, 1'b0, 1'b0, 5'h08, 1'b1, d1, 4'hF, 1'b0, 32'h0, 1'b0)));
        tbl.push_back(mkv(1'b0, 1'b0, 5'h00, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, ex(1'b0, 1'b1, 1'b0, 5'h0C, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0)));
        tbl.push_back(mkv(1'b0, 1'b0, 5'h00, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, ex(1'b0, 1'b1, 1'b1, 5'h0C, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0)));
        tbl.push_back(mkv(1'b0, 1'b0, 5'h00, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h1234_5678, 1'b1, ex(1'b0, 1'b1, 1'b1, 5'h0C, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0)));
        tbl.push_back(mkv(1'b0, 1'b0, 5'h00, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, db, 1'b1, ex(1'b0, 1'b1, 1'b1, 5'h0C, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0)));
        tbl.push_back(mkv(1'b0, 1'b0, 5'h00, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, ex(1'b1, 1'b0, 1'b0, 5'h0C, 1'b0, 32'h0, 4'h0, 1'b1, db, 1'b0)));
        // write 0x10 answered with pslverr; pslverr in SETUP must be ignored
        tbl.push_back(mkv(1'b0, 1'b1, 5'h10, 1'b1, d3, 4'h3, 1'b0, 1'b0, 32'h0, 1'b1, ex(1'b1, 1'b0, 1'b0, 5'h0C, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0)));
        tbl.push_back(mkv(1'b0, 1'b0, 5'h00, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 1'b1, ex(1'b0, 1'b1, 1'b0, 5'h10, 1'b1, d3, 4'h3, 1'b0, 32'h0, 1'b0)));
        tbl.push_back(mkv(1'b0, 1'b0, 5'h00, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b1, ex(1'b0, 1'b1, 1'b1, 5'h10, 1'b1, d3, 4'h3, 1'b0, 32'h0, 1'b0)));
        tbl.push_back(mkv(1'b0, 1'b1, 5'h04, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, ex(1'b1, 1'b0, 1'b0, 5'h10, 1'b1, d3, 4'h3, 1'b1, 32'h0, 1'b1)));
        tbl.push_back(mkv(1'b0, 1'b0, 5'h00, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 1'b1, ex(1'b0, 1'b1, 1'b0, 5'h04, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0)));
        tbl.push_back(mkv(1'b0, 1'b0, 5'h00, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, cf, 1'b1, ex(1'b0, 1'b1, 1'b1, 5'h04, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0)));
        tbl.push_back(mkv(1'b0, 1'b0, 5'h00, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, ex(1'b1, 1'b0, 1'b0, 5'h04, 1'b0, 32'h0, 4'h0, 1'b1, cf, 1'b0)));
        // reset in ACCESS of a read, with pready high in the same cycle
        tbl.push_back(mkv(1'b0, 1'b1, 5'h1C, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, ex(1'b1, 1'b0, 1'b0, 5'h04, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0)));
        tbl.push_back(mkv(1'b0, 1'b0, 5'h00, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, ex(1'b0, 1'b1, 1'b0, 5'h1C, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0)));
        tbl.push_back(mkv(1'b1, 1'b0, 5'h00, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'hBAD0_BAD0, 1'b1, ex(1'b0, 1'b1, 1'b1, 5'h1C, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0)));
        tbl.push_back(mkv(1'b0, 1'b0, 5'h00, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, idl0));
        tbl.push_back(mkv(1'b0, 1'b1, 5'h14, 1'b1, d5, 4'hC, 1'b0, 1'b0, 32'h0, 1'b1, idl0));
        tbl.push_back(mkv(1'b0, 1'b0, 5'h00, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1, ex(1'b0, 1'b1, 1'b0, 5'h14, 1'b1, d5, 4'hC, 1'b0, 32'h0, 1'b0)));
        tbl.push_back(mkv(1'b0, 1'b0, 5'h00, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1, ex(1'b0, 1'b1, 1'b1, 5'h14, 1'b1, d5, 4'hC, 1'b0, 32'h0, 1'b0)));
        tbl.push_back(mkv(1'b0, 1'b0, 5'h00, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, ex(1'b1, 1'b0, 1'b0, 5'h14, 1'b1, d5, 4'hC, 1'b1, 32'h0, 1'b0)));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge pclk);
            if (tbl[i].chk) begin
                check($sformatf("vec%0d", i), observe(), tbl[i].exp);
            end
            preset = tbl[i].rst; i_cmd_valid = tbl[i].v; i_cmd_addr = tbl[i].a;
            i_cmd_write = tbl[i].w; i_cmd_wdata = tbl[i].wd; i_cmd_strb = tbl[i].st;
            i_pready = tbl[i].rdy; i_pslverr = tbl[i].err; i_prdata = tbl[i].rd;
        end

        // Back-to-back reads with valid held high; slave returns an address-tagged word
        addrs[0] = 5'h00; addrs[1] = 5'h04; addrs[2] = 5'h08;
        acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
        nacc = 0; nrsp = 0;
        @(posedge pclk); #1;
        i_cmd_valid = 1'b1; i_cmd_addr = addrs[0]; i_cmd_write = 1'b0; i_pready = 1'b1; i_pslverr = 1'b0;
        for (int c = 0; c < 20 && nrsp < 3; c++) begin
            @(negedge pclk);
            i_prdata = 32'hABCD_E000 | {27'd0, o_paddr};
            hs = o_cmd_ready && i_cmd_valid;
            if (hs && nacc < 3) begin
                acc_cyc[nacc] = c;
                nacc++;
            end
            if (o_rsp_valid && nrsp < 3) begin
                check($sformatf("b2b_rdata%0d", nrsp), 80'(o_rsp_rdata), 80'(32'hABCD_E000 | {27'd0, addrs[nrsp]}));
                nrsp++;
            end
            @(posedge pclk); #1;
            if (hs) begin
                if (nacc < 3) i_cmd_addr = addrs[nacc];
                else i_cmd_valid = 1'b0;
            end
        end
        check("b2b_rsp_count", 80'(nrsp), 80'(3));
        check("b2b_gap01", 80'(acc_cyc[1] - acc_cyc[0]), 80'(3));
        check("b2b_gap12", 80'(acc_cyc[2] - acc_cyc[1]), 80'(3));
        i_cmd_valid = 1'b0;

        // Slave never raises pready
        @(posedge pclk); #1;
        i_pready = 1'b0; i_cmd_valid = 1'b1; i_cmd_addr = 5'h18; i_cmd_write = 1'b0; i_prdata = 32'h0;
        @(negedge pclk);
        check("stall_ready", 80'(o_cmd_ready), 80'(1));
        @(posedge pclk); #1;
        i_cmd_valid = 1'b0;
        rsp_cyc = -1; nacc_cyc = 0; rsp_rd = 32'h0; rsp_se = 1'b0; rsp_to = 1'b0; psel_at_rsp = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge pclk);
            if (o_rsp_valid) begin
                rsp_cyc = c; rsp_rd = o_rsp_rdata; rsp_se = o_rsp_slverr;
                rsp_to = o_rsp_timeout; psel_at_rsp = o_psel;
                break;
            end
            if (o_psel && o_penable) nacc_cyc++;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        check("to_rsp_cycle", 80'(rsp_cyc), 80'(6));
        check("to_access_cycles", 80'(nacc_cyc), 80'(4));
        check("to_flags", {47'd0, psel_at_rsp, rsp_rd, rsp_se, rsp_to}, {47'd0, 1'b0, 32'h0, 1'b1, 1'b1});
`else
        check("stall_no_rsp", 80'(rsp_cyc), 80'(-1));
        check("stall_access_cycles", 80'(nacc_cyc), 80'(44));
        check("stall_psel_now", {78'd0, o_psel, o_penable}, {78'd0, 1'b1, 1'b1});
        i_pready = 1'b1; i_prdata = 32'h5A5A_0000;
        rsp_cyc = -1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge pclk);
            if (o_rsp_valid) begin
                rsp_cyc = c; rsp_rd = o_rsp_rdata; rsp_se = o_rsp_slverr; rsp_to = o_rsp_timeout;
                break;
            end
        end
        check("stall_release_cycle", 80'(rsp_cyc), 80'(1));
        check("stall_release_rsp", {46'd0, rsp_rd, rsp_se, rsp_to}, {46'd0, 32'h5A5A_0000, 1'b0, 1'b0});
`endif
        i_pready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_apb_master
